mdio_slave: RTL and testbench

- Synthesizable Clause-22 MDIO management responder: the PHY-side counterpart of mdio_master.
- Oversamples MDC/MDIO on the system clock and decodes read and write frames addressed to PHY_ADDRESS.
- Serves a 32x16 register file and drives read data back onto the tristate MDIO pin.
- Sits in PHY models and FPGA-emulated management targets; a host-side port exposes the registers and write events.

---
 rtl/mdio_pkg.sv | 38 +++
 rtl/mdio_edge_sync.sv | 36 +++
 rtl/mdio_slave.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mdio_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO constants, the responder FSM state type and a field-length helper.
// Used by mdio_slave and mdio_edge_sync; mdio_master reuses the opcodes.
package mdio_pkg;

  localparam logic [1:0] MDIO_READ_OPCODE  = 2'b10;
  localparam logic [1:0] MDIO_WRITE_OPCODE = 2'b01;
  localparam logic [1:0] MDIO_WRITE_TA     = 2'b10;

  localparam int MDIO_PHYAD_W    = 5;
  localparam int MDIO_REGAD_W    = 5;
  localparam int MDIO_DATA_W     = 16;
  localparam int MDIO_TA_W       = 2;
  localparam int MDIO_FRAME_BITS = 32;

  typedef enum logic [2:0] {
    ST_PREAMBLE = 3'd0,
    ST_START    = 3'd1,
    ST_OPCODE   = 3'd2,
    ST_PHYAD    = 3'd3,
    ST_REGAD    = 3'd4,
    ST_TA       = 3'd5,
    ST_DATA     = 3'd6,
    ST_SKIP     = 3'd7
  } mdio_slave_state_t;

  // Index of the last bit of the field that a state collects.
  function automatic logic [3:0] field_last_bit(input mdio_slave_state_t st);
    case (st)
      ST_OPCODE: field_last_bit = 4'd1;
      ST_PHYAD:  field_last_bit = 4'(MDIO_PHYAD_W - 1);
      ST_REGAD:  field_last_bit = 4'(MDIO_REGAD_W - 1);
      ST_TA:     field_last_bit = 4'(MDIO_TA_W - 1);
      ST_DATA:   field_last_bit = 4'(MDIO_DATA_W - 1);
      default:   field_last_bit = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings mdc and mdio into the clk domain through equal-depth synchronizers and
// produces one-clk rise/fall strobes of mdc (SYNC_STAGES must be >= 2).
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise_o,
  output logic mdc_fall_o,
  output logic mdio_o
);

  logic [SYNC_STAGES-1:0] mdc_sync_q;
  logic [SYNC_STAGES-1:0] mdio_sync_q;
  logic                   mdc_prev_q;

  // Synchronizer chains; reset to the idle-high bus level so only a harmless fall can appear after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mdc_sync_q  <= '1;
      mdio_sync_q <= '1;
      mdc_prev_q  <= 1'b1;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
    end
  end

  assign mdc_rise_o = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
  assign mdc_fall_o = ~mdc_sync_q[SYNC_STAGES-1] & mdc_prev_q;
  assign mdio_o     = mdio_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder serving a 32x16 register file at PHY_ADDRESS.
// Optional MDIO_SLAVE_PREAMBLE_SUPPRESSION_EN: after the first completed frame, a single preamble '1' suffices.
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDRESS  = 5'h00,
  parameter int         MIN_PREAMBLE = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic [4:0]  host_addr,
  output logic [15:0] host_rdata,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_valid,
  output logic        frame_error
);

  localparam int             PCW     = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PCW-1:0] PRE_MAX = PCW'(MIN_PREAMBLE);
  localparam logic [PCW-1:0] PRE_ONE = PCW'(1);

  logic mdc_rise_s, mdc_fall_s, mdio_s, last_s;
  logic [PCW-1:0] pre_thr_s;

  mdio_slave_state_t state_q, state_d;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [4:0]     frame_cnt_q, frame_cnt_d;
  logic [1:0]     op_q, op_d;
  logic           is_read_q, is_read_d;
  logic [4:0]     phyad_q, phyad_d;
  logic [4:0]     regad_q, regad_d;
  logic           ta_q, ta_d;
  logic [15:0]    shreg_q, shreg_d;
  logic           rd_pend_q, rd_pend_d;
  logic           mdio_o_q, mdio_o_d;
  logic           mdio_t_q, mdio_t_d;
  logic           wr_valid_q, wr_valid_d;
  logic [4:0]     wr_addr_q, wr_addr_d;
  logic [15:0]    wr_data_q, wr_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           frame_err_q, frame_err_d;
  logic [15:0]    host_rdata_q;
  logic [15:0]    regs_q [32];

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .mdc_i     (mdc),
    .mdio_i    (mdio_i),
    .mdc_rise_o(mdc_rise_s),
    .mdc_fall_o(mdc_fall_s),
    .mdio_o    (mdio_s)
  );

`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESSION_EN
  logic seen_q, seen_d;
  assign pre_thr_s = seen_q ? PRE_ONE : PRE_MAX;

  // Remembers that one frame has completed since reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
    end
  end
`else
  assign pre_thr_s = PRE_MAX;
`endif

  assign last_s = (bit_cnt_q == field_last_bit(state_q));

  // Frame decoder: rises sample the bus, falls update the driven pin.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    op_d        = op_q;
    is_read_d   = is_read_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    ta_d        = ta_q;
    shreg_d     = shreg_q;
    rd_pend_d   = rd_pend_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESSION_EN
    seen_d      = seen_q;
`endif
    if (mdc_rise_s) begin
      bit_cnt_d   = bit_cnt_q + 4'd1;
      frame_cnt_d = frame_cnt_q + 5'd1;
      case (state_q)
        ST_PREAMBLE: begin
          bit_cnt_d = 4'd0;
          if (mdio_s) begin
            pre_cnt_d = (pre_cnt_q < PRE_MAX) ? pre_cnt_q + PRE_ONE : pre_cnt_q;
          end else if (pre_cnt_q >= pre_thr_s) begin
            state_d     = ST_START;
            pre_cnt_d   = {PCW{1'b0}};
            frame_cnt_d = 5'd1;
          end else begin
            pre_cnt_d = {PCW{1'b0}};
          end
        end
        ST_START: begin
          bit_cnt_d = 4'd0;
          if (mdio_s) begin
            state_d = ST_OPCODE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_PREAMBLE;
          end
        end
        ST_OPCODE: begin
          op_d = {op_q[0], mdio_s};
          if (last_s) begin
            bit_cnt_d = 4'd0;
            is_read_d = (op_d == MDIO_READ_OPCODE);
            state_d   = (op_d == MDIO_READ_OPCODE || op_d == MDIO_WRITE_OPCODE) ? ST_PHYAD : ST_SKIP;
          end else begin
            state_d = ST_OPCODE;
          end
        end
        ST_PHYAD: begin
          phyad_d = {phyad_q[3:0], mdio_s};
          if (last_s) begin
            bit_cnt_d = 4'd0;
            state_d   = (phyad_d == PHY_ADDRESS) ? ST_REGAD : ST_SKIP;
          end else begin
            state_d = ST_PHYAD;
          end
        end
        ST_REGAD: begin
          regad_d = {regad_q[3:0], mdio_s};
          if (last_s) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_TA;
            shreg_d   = regs_q[regad_d];
          end else begin
            state_d = ST_REGAD;
          end
        end
        ST_TA: begin
          ta_d = mdio_s;
          if (!last_s) begin
            state_d = ST_TA;
          end else if (!is_read_q && {ta_q, mdio_s} != MDIO_WRITE_TA) begin
            bit_cnt_d   = 4'd0;
            frame_err_d = 1'b1;
            state_d     = ST_SKIP;
          end else begin
            bit_cnt_d = 4'd0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          shreg_d = is_read_q ? shreg_q : {shreg_q[14:0], mdio_s};
          if (last_s) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_PREAMBLE;
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESSION_EN
            seen_d    = 1'b1;
`endif
            if (is_read_q) begin
              rd_pend_d = 1'b1;
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = regad_q;
              wr_data_d  = {shreg_q[14:0], mdio_s};
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_SKIP: begin
          bit_cnt_d = 4'd0;
          state_d   = (frame_cnt_q == 5'(MDIO_FRAME_BITS - 1)) ? ST_PREAMBLE : ST_SKIP;
        end
        default: begin
          state_d   = ST_PREAMBLE;
          pre_cnt_d = {PCW{1'b0}};
        end
      endcase
    end else if (mdc_fall_s) begin
      // The release after the last read bit wins over everything else on a fall.
      if (rd_pend_q) begin
        mdio_t_d   = 1'b1;
        mdio_o_d   = 1'b0;
        rd_valid_d = 1'b1;
        rd_pend_d  = 1'b0;
      end else if (is_read_q && state_q == ST_TA && bit_cnt_q == 4'd1) begin
        mdio_t_d = 1'b0;
        mdio_o_d = 1'b0;
      end else if (is_read_q && state_q == ST_DATA) begin
        mdio_t_d = 1'b0;
        mdio_o_d = shreg_q[15];
        shreg_d  = {shreg_q[14:0], 1'b0};
      end else begin
        mdio_t_d = mdio_t_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_PREAMBLE;
      pre_cnt_q   <= {PCW{1'b0}};
      bit_cnt_q   <= 4'd0;
      frame_cnt_q <= 5'd0;
      op_q        <= 2'b00;
      is_read_q   <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      ta_q        <= 1'b0;
      shreg_q     <= 16'h0000;
      rd_pend_q   <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_t_q    <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 16'h0000;
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      op_q        <= op_d;
      is_read_q   <= is_read_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      ta_q        <= ta_d;
      shreg_q     <= shreg_d;
      rd_pend_q   <= rd_pend_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_valid_q  <= rd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file and host port; a same-clk host read sees the pre-commit value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 16'h0000;
      end
      host_rdata_q <= 16'h0000;
    end else begin
      if (wr_valid_d) begin
        regs_q[wr_addr_d] <= wr_data_d;
      end
      host_rdata_q <= regs_q[host_addr];
    end
  end

  assign mdio_o      = mdio_o_q;
  assign mdio_t      = mdio_t_q;
  assign host_rdata  = host_rdata_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_valid    = rd_valid_q;
  assign frame_error = frame_err_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Self-checking bench for mdio_slave: a bit-banged MDIO master with a pulled-up
// bus, a write-event scoreboard and directed frame scenarios.
module tb_mdio_slave;

  localparam logic [4:0] PHY = 5'h0c;
  localparam int         HALF = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mdc;
  logic        m_oe;
  logic        m_out;
  logic        mdio_o, mdio_t;
  logic [4:0]  host_addr;
  logic [15:0] host_rdata;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        frame_error;
  logic        mdio_line;

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_wr[$];

  int n_vec = 0;
  int n_miss = 0;
  int drv_cnt = 0;
  int rd_cnt = 0;
  int fe_cnt = 0;

  assign mdio_line = !mdio_t ? mdio_o : (m_oe ? m_out : 1'b1);

  always #5 clk = ~clk;

  mdio_slave #(.PHY_ADDRESS(PHY), .MIN_PREAMBLE(32), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mdc        (mdc),
    .mdio_i     (mdio_line),
    .mdio_o     (mdio_o),
    .mdio_t     (mdio_t),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .frame_error(frame_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-event scoreboard plus pulse/drive counters.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!mdio_t) drv_cnt++;
      if (rd_valid) rd_cnt++;
      if (frame_error) fe_cnt++;
      if (wr_valid) begin
        if (exp_wr.size() == 0) begin
          check_eq("wr_unexpected", {11'd0, wr_addr, wr_data}, 32'hffffffff);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check_eq("wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
          check_eq("wr_data", {16'd0, wr_data}, {16'd0, e.d});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wr_word(input logic [4:0] phy, input logic [4:0] ra,
                                          input logic [15:0] d, input logic [1:0] ta);
    return {2'b01, 2'b01, phy, ra, ta, d};
  endfunction

  task automatic mdc_bit(input logic oe, input logic val, output logic smp);
    mdc   = 1'b0;
    m_oe  = oe;
    m_out = val;
    repeat (HALF) @(posedge clk);
    #1 smp = mdio_line;
    mdc = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_raw(input int pre, input logic [31:0] w);
    logic s;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 31; i >= 0; i--) mdc_bit(1'b1, w[i], s);
    m_oe = 1'b0;
  endtask

  // Full read frame; rst_idx >= 0 pulses reset_n during that bit's low phase.
  task automatic do_read(input logic [4:0] ra, input int rst_idx, output logic [15:0] rd);
    logic [31:0] w;
    logic s;
    int rc0;
    w   = {2'b01, 2'b10, PHY, ra, 18'h3ffff};
    rd  = 16'h0000;
    rc0 = rd_cnt;
    for (int i = 0; i < 32; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 0; i < 32; i++) begin
      if (i == rst_idx) begin
        mdc  = 1'b0;
        m_oe = 1'b0;
        repeat (HALF) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #1 check_eq("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
        reset_n = 1'b1;
        mdc = 1'b1;
        repeat (HALF) @(posedge clk);
      end else begin
        mdc_bit(i < 14, w[31-i], s);
        if (rst_idx < 0 && i == 14) check_eq("ta1_released", {31'd0, mdio_t}, 32'd1);
        if (rst_idx < 0 && i == 15) begin
          check_eq("ta2_value", {31'd0, s}, 32'd0);
          check_eq("ta2_driven", {31'd0, mdio_t}, 32'd0);
        end
        if (rst_idx < 0 && i == 31) check_eq("last_bit_driven", {31'd0, mdio_t}, 32'd0);
        if (i >= 16) rd = {rd[14:0], s};
      end
    end
    mdc = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    if (rst_idx < 0) begin
      check_eq("rd_release", {31'd0, mdio_t}, 32'd1);
      check_eq("rd_valid_cnt", rd_cnt - rc0, 32'd1);
    end
  endtask

  task automatic host_chk(input string tag, input logic [4:0] a, input logic [15:0] exp);
    host_addr = a;
    repeat (2) @(posedge clk);
    #1 check_eq(tag, {16'd0, host_rdata}, {16'd0, exp});
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rd;
    int d0, f0;
    reset_n   = 1'b0;
    mdc       = 1'b1;
    m_oe      = 1'b0;
    m_out     = 1'b1;
    host_addr = 5'h18;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
    check_eq("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
    check_eq("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
    check_eq("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_frame_error", {31'd0, frame_error}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Basic write, then read back over the bus.
    d0 = drv_cnt;
    exp_wr.push_back('{a: 5'h18, d: 16'haaa5});
    send_raw(32, wr_word(PHY, 5'h18, 16'haaa5, 2'b10));
    check_eq("wr_nodrive", drv_cnt - d0, 32'd0);
    host_chk("host_18", 5'h18, 16'haaa5);
    do_read(5'h18, -1, rd);
    check_eq("rd_18", {16'd0, rd}, {16'd0, 16'haaa5});

    // Write to another PHY must be ignored.
    d0 = drv_cnt;
    send_raw(32, wr_word(5'h0d, 5'h18, 16'h1234, 2'b10));
    check_eq("otherphy_nodrive", drv_cnt - d0, 32'd0);
    host_chk("otherphy_host", 5'h18, 16'haaa5);
    do_read(5'h18, -1, rd);
    check_eq("otherphy_rd", {16'd0, rd}, {16'd0, 16'haaa5});

    // Preamble length boundary: 31 ones rejected, 32 accepted.
    pulse_reset();
    send_raw(31, wr_word(PHY, 5'h05, 16'h5555, 2'b10));
    host_chk("pre31_ignored", 5'h05, 16'h0000);
    exp_wr.push_back('{a: 5'h05, d: 16'h5555});
    send_raw(32, wr_word(PHY, 5'h05, 16'h5555, 2'b10));
    host_chk("pre32_accepted", 5'h05, 16'h5555);

    // Bad write turnaround.
    f0 = fe_cnt;
    send_raw(32, wr_word(PHY, 5'h05, 16'hffff, 2'b11));
    check_eq("bad_ta_frame_error", fe_cnt - f0, 32'd1);
    host_chk("bad_ta_unchanged", 5'h05, 16'h5555);

    // Reset during read data bit 7 clears the register file.
    exp_wr.push_back('{a: 5'h18, d: 16'haaa5});
    send_raw(32, wr_word(PHY, 5'h18, 16'haaa5, 2'b10));
    host_chk("pre_abort_host", 5'h18, 16'haaa5);
    do_read(5'h18, 24, rd);
    do_read(5'h18, -1, rd);
    check_eq("post_reset_rd", {16'd0, rd}, 32'd0);

    // Short-preamble frame after a completed frame.
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESSION_EN
    exp_wr.push_back('{a: 5'h03, d: 16'hbeef});
    send_raw(1, wr_word(PHY, 5'h03, 16'hbeef, 2'b10));
    host_chk("suppressed_pre", 5'h03, 16'hbeef);
`else
    send_raw(1, wr_word(PHY, 5'h03, 16'hbeef, 2'b10));
    host_chk("short_pre_ignored", 5'h03, 16'h0000);
`endif

    repeat (10) @(posedge clk);
    check_eq("wr_events_outstanding", exp_wr.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
